// File: rtl/pulse_period_meter_if.sv
// Result port of pulse_period_meter: the measured period and its flags, carried
// on a valid/ready handshake. The meter is the master, the consumer is the slave.
interface pulse_period_meter_if #(parameter int WIDTH = 16);
  logic [WIDTH-1:0] period_o;
  logic             overflow_o;
  logic             valid_o;
  logic             ready_i;
  logic             dropped_o;

  modport master (output period_o, output overflow_o, output valid_o, output dropped_o,
                  input ready_i);
  modport slave  (input period_o, input overflow_o, input valid_o, input dropped_o,
                  output ready_i);
endinterface

// File: rtl/pulse_period_meter.sv
// Counts clk cycles between rising edges of pulse_in and hands each interval out on a
// valid/ready port. Optional min/max statistics are built when PERIOD_METER_MINMAX_EN is defined.
module pulse_period_meter #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 pulse_in,
  pulse_period_meter_if.master res
`ifdef PERIOD_METER_MINMAX_EN
  ,
  output logic [WIDTH-1:0]     min_o,
  output logic [WIDTH-1:0]     max_o,
  input  logic                 clear_stats_i
`endif
);

  localparam logic [0:0]       IDLE    = 1'b0;
  localparam logic [0:0]       MEASURE = 1'b1;
  localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ONES    = {WIDTH{1'b1}};

  logic [0:0]       state_r;
  logic [0:0]       state_n_s;
  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] count_n_s;
  logic             sat_r;
  logic             sat_n_s;
  logic             pulse_prev_r;
  logic             edge_s;
  logic             capture_s;
  logic [WIDTH-1:0] period_r;
  logic             overflow_r;
  logic             valid_r;
  logic             dropped_r;

  assign edge_s    = pulse_in & ~pulse_prev_r;
  assign capture_s = enable & (state_r == MEASURE) & edge_s;

  // Next-state and interval counter; the count sticks at all-ones instead of wrapping.
  always_comb begin
    state_n_s = state_r;
    count_n_s = count_r;
    sat_n_s   = sat_r;
    if (!enable) begin
      state_n_s = IDLE;
      count_n_s = ZERO;
      sat_n_s   = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          sat_n_s = 1'b0;
          if (edge_s) begin
            state_n_s = MEASURE;
            count_n_s = ONE;
          end else begin
            state_n_s = IDLE;
            count_n_s = ZERO;
          end
        end
        MEASURE: begin
          state_n_s = MEASURE;
          if (edge_s) begin
            count_n_s = ONE;
            sat_n_s   = 1'b0;
          end else if (count_r == ONES) begin
            count_n_s = ONES;
            sat_n_s   = 1'b1;
          end else begin
            count_n_s = count_r + ONE;
            sat_n_s   = sat_r;
          end
        end
        default: begin
          state_n_s = IDLE;
          count_n_s = ZERO;
          sat_n_s   = 1'b0;
        end
      endcase
    end
  end

  // Sequential state, result capture and handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      count_r      <= ZERO;
      sat_r        <= 1'b0;
      pulse_prev_r <= 1'b1;
      period_r     <= ZERO;
      overflow_r   <= 1'b0;
      valid_r      <= 1'b0;
      dropped_r    <= 1'b0;
    end else begin
      state_r      <= state_n_s;
      count_r      <= count_n_s;
      sat_r        <= sat_n_s;
      pulse_prev_r <= pulse_in;
      dropped_r    <= capture_s & valid_r & ~res.ready_i;
      if (capture_s) begin
        period_r   <= count_r;
        overflow_r <= sat_r;
        valid_r    <= 1'b1;
      end else if (valid_r && res.ready_i) begin
        valid_r    <= 1'b0;
      end else begin
        valid_r    <= valid_r;
      end
    end
  end

  assign res.period_o   = period_r;
  assign res.overflow_o = overflow_r;
  assign res.valid_o    = valid_r;
  assign res.dropped_o  = dropped_r;

`ifdef PERIOD_METER_MINMAX_EN
  logic [WIDTH-1:0] min_r;
  logic [WIDTH-1:0] max_r;

  // Running extremes of captured periods; a clear coinciding with a capture seeds both with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      min_r <= ONES;
      max_r <= ZERO;
    end else if (capture_s) begin
      if (clear_stats_i) begin
        min_r <= count_r;
        max_r <= count_r;
      end else begin
        min_r <= (count_r < min_r) ? count_r : min_r;
        max_r <= (count_r > max_r) ? count_r : max_r;
      end
    end else if (clear_stats_i) begin
      min_r <= ONES;
      max_r <= ZERO;
    end else begin
      min_r <= min_r;
      max_r <= max_r;
    end
  end

  assign min_o = min_r;
  assign max_o = max_r;
`endif

endmodule
